// File: rtl/sat_pkg.sv
// Purpose: shared constants and types for the WalkSAT flip-select slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sat_pkg;

  localparam int NSAT     = 3;
  localparam int VAR_BITS = 10;

  // Selector write/select strobe encoding; one code per literal slot, then select.
  localparam logic [1:0] WREN_IDLE   = 2'b00;
  localparam logic [1:0] WREN_SLOT0  = 2'b01;
  localparam logic [1:0] WREN_SLOT1  = 2'b10;
  localparam logic [1:0] WREN_SELECT = 2'b11;

  // Selector reports this when no slot could be chosen.
  localparam logic [1:0] SEL_INVALID = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/flip_select_controller_lfsr32.sv
// Purpose: 32-bit Galois LFSR (x^32+x^22+x^2+x+1) feeding the selector random input.
// Latency: new word every cycle; q is the register itself.
// Backpressure: none, free-running outside reset.
// Ports: clk, reset (sync, active-high), q (current LFSR state).
module lfsr32 #(
  parameter logic [31:0] SEED = 32'h1ACE5EED
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] q
);

  // An all-zero state would lock up the register, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] TAP_MASK = 32'h80200003;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED_EFF;
    end else if (q[0]) begin
      q <= (q >> 1) ^ TAP_MASK;
    end else begin
      q <= q >> 1;
    end
  end

endmodule

// File: rtl/flip_select_controller.sv
// Purpose: sequences one unsatisfied clause through occurrence-memory reads and the flip selector.
// Latency: first read C = cycle after acceptance; wren 11 at C+2+RD_LATENCY; flip_valid_o at C+4+RD_LATENCY.
// Backpressure: one clause in flight; clause_ready_o low until the cycle after the flip handshake.
// Ports: clause_* (clause in, valid/ready), mem_rd_* (read strobe/addr), wren_o/bv_valid_o/rand_o/
//        sel_selected_i (selector side), flip_* (result out, valid/ready), error_o (dropped-clause pulse).
module flip_select_controller
  import sat_pkg::*;
#(
  parameter int          RD_LATENCY = 2,
  parameter logic [31:0] LFSR_SEED  = 32'h1ACE5EED
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clause_valid_i,
  output logic                     clause_ready_o,
  input  logic [NSAT*VAR_BITS-1:0] clause_vars_i,
  input  logic [NSAT-1:0]          clause_lit_valid_i,
  output logic                     mem_rd_en_o,
  output logic [VAR_BITS-1:0]      mem_rd_addr_o,
  output logic [1:0]               wren_o,
  output logic [NSAT-1:0]          bv_valid_o,
  output logic [31:0]              rand_o,
  input  logic [1:0]               sel_selected_i,
  output logic                     flip_valid_o,
  input  logic                     flip_ready_i,
  output logic [VAR_BITS-1:0]      flip_var_o,
  output logic [1:0]               flip_slot_o,
  output logic                     error_o
);

  state_t              state_q, state_d;
  logic [1:0]          slot_q;
  logic [VAR_BITS-1:0] vars_q [NSAT];
  logic [NSAT-1:0]     lit_q;
  logic [1:0]          wren_dl [RD_LATENCY];
  logic [1:0]          issue_code;
  logic                accept;
  logic                sel_bad;

  assign accept  = clause_valid_i && (state_q == IDLE);
  assign sel_bad = (sel_selected_i == SEL_INVALID);

  // The strobe leaves the delay line exactly when the slot's read data reaches the selector.
  assign wren_o     = wren_dl[RD_LATENCY-1];
  assign bv_valid_o = (wren_o == WREN_SELECT) ? lit_q : '0;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (clause_lit_valid_i != '0)) state_d = ISSUE;
      ISSUE:   if (slot_q == 2'd2) state_d = DRAIN;
      DRAIN:   if (wren_o == WREN_SELECT) state_d = CAPTURE;
      CAPTURE: state_d = sel_bad ? IDLE : HOLD;
      HOLD:    if (flip_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    clause_ready_o = (state_q == IDLE);
    mem_rd_en_o    = (state_q == ISSUE);
    flip_valid_o   = (state_q == HOLD);
    mem_rd_addr_o  = '0;
    issue_code     = WREN_IDLE;
    if (state_q == ISSUE) begin
      mem_rd_addr_o = vars_q[slot_q];
      // slot 0/1/2 maps onto WREN_SLOT0/WREN_SLOT1/WREN_SELECT
      issue_code    = slot_q + 2'd1;
    end
  end

  // Datapath: clause latch, slot counter, strobe delay line, flip result, error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q      <= 2'd0;
      lit_q       <= '0;
      flip_var_o  <= '0;
      flip_slot_o <= 2'd0;
      error_o     <= 1'b0;
      for (int k = 0; k < NSAT; k++) vars_q[k] <= '0;
      for (int i = 0; i < RD_LATENCY; i++) wren_dl[i] <= WREN_IDLE;
    end else begin
      if (accept) begin
        lit_q <= clause_lit_valid_i;
        for (int k = 0; k < NSAT; k++) vars_q[k] <= clause_vars_i[k*VAR_BITS +: VAR_BITS];
      end

      if (state_q == ISSUE && slot_q != 2'd2) begin
        slot_q <= slot_q + 2'd1;
      end else begin
        slot_q <= 2'd0;
      end

      wren_dl[0] <= issue_code;
      for (int i = 1; i < RD_LATENCY; i++) wren_dl[i] <= wren_dl[i-1];

      if (state_q == CAPTURE && !sel_bad) begin
        flip_var_o  <= vars_q[sel_selected_i];
        flip_slot_o <= sel_selected_i;
      end

      // A clause with no literals, or one the selector rejects, is dropped with a pulse.
      error_o <= (accept && (clause_lit_valid_i == '0)) ||
                 (state_q == CAPTURE && sel_bad);
    end
  end

  lfsr32 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (rand_o)
  );

endmodule

// File: tb/tb_flip_select_controller.sv
// Purpose: directed bench for flip_select_controller with RD_LATENCY=2.
// Latency: checks every cycle of each clause from acceptance to handshake.
// Backpressure: exercises a stalled downstream (flip_ready_i low).
module tb_flip_select_controller;
  import sat_pkg::*;

  localparam int          RL   = 2;
  localparam logic [31:0] SEED = 32'h1ACE5EED;

  logic                     clk;
  logic                     reset;
  logic                     clause_valid_i;
  logic                     clause_ready_o;
  logic [NSAT*VAR_BITS-1:0] clause_vars_i;
  logic [NSAT-1:0]          clause_lit_valid_i;
  logic                     mem_rd_en_o;
  logic [VAR_BITS-1:0]      mem_rd_addr_o;
  logic [1:0]               wren_o;
  logic [NSAT-1:0]          bv_valid_o;
  logic [31:0]              rand_o;
  logic [1:0]               sel_selected_i;
  logic                     flip_valid_o;
  logic                     flip_ready_i;
  logic [VAR_BITS-1:0]      flip_var_o;
  logic [1:0]               flip_slot_o;
  logic                     error_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] lfsr_m;
  logic [31:0] rand_prev;

  flip_select_controller #(
    .RD_LATENCY (RL),
    .LFSR_SEED  (SEED)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .clause_valid_i     (clause_valid_i),
    .clause_ready_o     (clause_ready_o),
    .clause_vars_i      (clause_vars_i),
    .clause_lit_valid_i (clause_lit_valid_i),
    .mem_rd_en_o        (mem_rd_en_o),
    .mem_rd_addr_o      (mem_rd_addr_o),
    .wren_o             (wren_o),
    .bv_valid_o         (bv_valid_o),
    .rand_o             (rand_o),
    .sel_selected_i     (sel_selected_i),
    .flip_valid_o       (flip_valid_o),
    .flip_ready_i       (flip_ready_i),
    .flip_var_o         (flip_var_o),
    .flip_slot_o        (flip_slot_o),
    .error_o            (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h80200003) : (s >> 1);
  endfunction

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic step();
    logic r;
    r = reset;
    @(posedge clk);
    lfsr_m = r ? SEED : lfsr_next(lfsr_m);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers a clause and checks reads/strobes through CAPTURE; returns in cycle C+6.
  task automatic run_clause(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c,
                            input logic [2:0] lit, input logic [1:0] sel);
    clause_vars_i      = {c, b, a};
    clause_lit_valid_i = lit;
    sel_selected_i     = sel;
    clause_valid_i     = 1'b1;
    chk("ready_before_accept", clause_ready_o, 1);
    step();                                            // C
    clause_valid_i = 1'b0;
    chk("C_rd_en", mem_rd_en_o, 1);
    chk("C_addr", mem_rd_addr_o, a);
    chk("C_ready_low", clause_ready_o, 0);
    chk("C_wren", wren_o, WREN_IDLE);
    step();                                            // C+1
    chk("C1_rd_en", mem_rd_en_o, 1);
    chk("C1_addr", mem_rd_addr_o, b);
    chk("C1_wren", wren_o, WREN_IDLE);
    step();                                            // C+2
    chk("C2_rd_en", mem_rd_en_o, 1);
    chk("C2_addr", mem_rd_addr_o, c);
    chk("C2_wren", wren_o, WREN_SLOT0);
    chk("C2_bv", bv_valid_o, 0);
    step();                                            // C+3
    chk("C3_rd_en", mem_rd_en_o, 0);
    chk("C3_wren", wren_o, WREN_SLOT1);
    chk("C3_bv", bv_valid_o, 0);
    step();                                            // C+4
    chk("C4_wren", wren_o, WREN_SELECT);
    chk("C4_bv", bv_valid_o, lit);
    chk("C4_flip_valid", flip_valid_o, 0);
    step();                                            // C+5, CAPTURE
    chk("C5_wren", wren_o, WREN_IDLE);
    chk("C5_bv", bv_valid_o, 0);
    chk("C5_flip_valid", flip_valid_o, 0);
    chk("C5_ready_low", clause_ready_o, 0);
    step();                                            // C+6
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset              = 1'b1;
    clause_valid_i     = 1'b0;
    clause_vars_i      = '0;
    clause_lit_valid_i = '0;
    sel_selected_i     = 2'd0;
    flip_ready_i       = 1'b1;
    lfsr_m             = SEED;

    // 1: reset state and idle behaviour
    step(); step();
    chk("rst_rand_seed", rand_o, SEED);
    reset = 1'b0;
    chk("rst_ready", clause_ready_o, 1);
    chk("rst_rd_en", mem_rd_en_o, 0);
    chk("rst_addr", mem_rd_addr_o, 0);
    chk("rst_wren", wren_o, WREN_IDLE);
    chk("rst_bv", bv_valid_o, 0);
    chk("rst_flip_valid", flip_valid_o, 0);
    chk("rst_flip_var", flip_var_o, 0);
    chk("rst_flip_slot", flip_slot_o, 0);
    chk("rst_error", error_o, 0);
    for (int i = 0; i < 5; i++) begin
      rand_prev = rand_o;
      step();
      chk("idle_ready", clause_ready_o, 1);
      chk("idle_wren", wren_o, WREN_IDLE);
      chk("idle_rd_en", mem_rd_en_o, 0);
      chk("idle_flip_valid", flip_valid_o, 0);
      chk("idle_error", error_o, 0);
      chk("idle_rand_model", rand_o, lfsr_m);
      chk("idle_rand_changes", rand_o != rand_prev, 1);
    end

    // 2: full clause, selector picks slot 1
    flip_ready_i = 1'b1;
    run_clause(10'd5, 10'd9, 10'd12, 3'b111, 2'b01);
    chk("t2_flip_valid", flip_valid_o, 1);
    chk("t2_flip_var", flip_var_o, 9);
    chk("t2_flip_slot", flip_slot_o, 1);
    chk("t2_ready_low", clause_ready_o, 0);
    step();
    chk("t2_after_hs_valid", flip_valid_o, 0);
    chk("t2_after_hs_ready", clause_ready_o, 1);

    // 3: downstream stalls for 10 cycles
    flip_ready_i = 1'b0;
    run_clause(10'd5, 10'd9, 10'd12, 3'b111, 2'b01);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", flip_valid_o, 1);
      chk("t3_hold_var", flip_var_o, 9);
      chk("t3_hold_slot", flip_slot_o, 1);
      chk("t3_hold_ready", clause_ready_o, 0);
      chk("t3_hold_rd_en", mem_rd_en_o, 0);
      step();
    end
    chk("t3_still_valid", flip_valid_o, 1);
    flip_ready_i = 1'b1;
    step();
    chk("t3_ready_after_hs", clause_ready_o, 1);
    chk("t3_valid_after_hs", flip_valid_o, 0);

    // 4: slot 2 absent from the literal mask, selector picks slot 2
    run_clause(10'd7, 10'd20, 10'd300, 3'b011, 2'b10);
    chk("t4_flip_valid", flip_valid_o, 1);
    chk("t4_flip_var", flip_var_o, 300);
    chk("t4_flip_slot", flip_slot_o, 2);
    step();
    chk("t4_ready", clause_ready_o, 1);

    // 5a: empty clause is dropped
    clause_vars_i      = {10'd3, 10'd2, 10'd1};
    clause_lit_valid_i = 3'b000;
    clause_valid_i     = 1'b1;
    step();
    clause_valid_i = 1'b0;
    chk("t5_err_pulse", error_o, 1);
    chk("t5_ready", clause_ready_o, 1);
    chk("t5_rd_en", mem_rd_en_o, 0);
    chk("t5_wren", wren_o, WREN_IDLE);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_err_clear", error_o, 0);
      chk("t5_rd_en_idle", mem_rd_en_o, 0);
      chk("t5_wren_idle", wren_o, WREN_IDLE);
      chk("t5_ready_idle", clause_ready_o, 1);
    end

    // 5b: selector reports no choice
    run_clause(10'd1, 10'd2, 10'd3, 3'b111, SEL_INVALID);
    chk("t5b_err_pulse", error_o, 1);
    chk("t5b_no_flip", flip_valid_o, 0);
    chk("t5b_ready", clause_ready_o, 1);
    chk("t5b_flip_var_kept", flip_var_o, 300);
    step();
    chk("t5b_err_clear", error_o, 0);
    chk("t5b_no_flip_later", flip_valid_o, 0);

    // 6: reset during the second ISSUE cycle
    clause_vars_i      = {10'd33, 10'd22, 10'd11};
    clause_lit_valid_i = 3'b111;
    sel_selected_i     = 2'd0;
    clause_valid_i     = 1'b1;
    step();
    clause_valid_i = 1'b0;
    chk("t6_C_addr", mem_rd_addr_o, 11);
    step();
    chk("t6_C1_addr", mem_rd_addr_o, 22);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_rd_en", mem_rd_en_o, 0);
    chk("t6_rst_wren", wren_o, WREN_IDLE);
    chk("t6_rst_ready", clause_ready_o, 1);
    chk("t6_rst_rand", rand_o, SEED);
    chk("t6_rst_flip_var", flip_var_o, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_quiet_wren", wren_o, WREN_IDLE);
      chk("t6_quiet_rd_en", mem_rd_en_o, 0);
      chk("t6_quiet_ready", clause_ready_o, 1);
      chk("t6_quiet_flip", flip_valid_o, 0);
      chk("t6_rand_model", rand_o, lfsr_m);
    end
    run_clause(10'd100, 10'd200, 10'd400, 3'b101, 2'b00);
    chk("t6_flip_valid", flip_valid_o, 1);
    chk("t6_flip_var", flip_var_o, 100);
    chk("t6_flip_slot", flip_slot_o, 0);
    step();
    chk("t6_ready_end", clause_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
